// File: rtl/ws2812_frame_sched.sv
// ws2812_frame_sched
//
// Frame scheduler and double-buffered pixel store for a ws2812c-style serial
// LED driver. A host fills the back buffer and commits the frame. The commit is
// held pending until the next frame boundary (LATCH), where the back buffer is
// copied into the front buffer in one cycle. Each frame holds the driver in
// reset, then serves its pixel requests from the front buffer. Frames repeat
// every FRAME_CYCLES cycles once the first commit has arrived.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   wr_valid/wr_ready     host pixel write handshake (ready low while a swap is pending)
//   wr_addr, wr_data      pixel index and {red, green, blue} value
//   commit                one-cycle pulse: back buffer complete
//   commit_done           one-cycle pulse when the buffer swap happens
//   drv_reset             active-high reset to the driver (held at frame start)
//   drv_address           pixel index requested by the driver
//   drv_new_address       driver strobe: it has moved to drv_address
//   red_out/green_out/blue_out  pixel data, one cycle after drv_address
//   busy                  high outside IDLE
//   frame_overrun         sticky: streaming outlasted the frame period
//
// Optional feature macro: WS2812_GAMMA_EN
//   defined   -> each channel c is output as (c*c)>>8 in the same register stage
//   undefined -> raw buffer values are passed through

module ws2812_frame_sched #(
  parameter int NUM_LEDS     = 8,
  parameter int ADDR_BITS    = 3,
  parameter int FRAME_CYCLES = 800_000,
  parameter int RESET_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [23:0]          wr_data,
  input  logic                 commit,
  output logic                 commit_done,
  output logic                 drv_reset,
  input  logic [ADDR_BITS-1:0] drv_address,
  input  logic                 drv_new_address,
  output logic [7:0]           red_out,
  output logic [7:0]           green_out,
  output logic [7:0]           blue_out,
  output logic                 busy,
  output logic                 frame_overrun
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int TW    = $clog2(FRAME_CYCLES);
  localparam int RW    = $clog2(RESET_CYCLES + 1);
  localparam int SW    = $clog2(NUM_LEDS + 1);
  localparam int AW1   = ADDR_BITS + 1;

  localparam logic [TW-1:0]  TIMER_MAX   = TW'(FRAME_CYCLES - 1);
  localparam logic [RW-1:0]  RST_LAST    = RW'(RESET_CYCLES - 1);
  localparam logic [SW-1:0]  SERVED_LAST = SW'(NUM_LEDS - 1);
  localparam logic [AW1-1:0] LED_LIMIT   = AW1'(NUM_LEDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LATCH,
    S_STREAM,
    S_WAIT
  } state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [RW-1:0]   rst_cnt;
  logic [SW-1:0]   served;
  logic            swap_pending;
  logic            latch_go;
  logic [23:0]     back  [DEPTH];
  logic [23:0]     front [DEPTH];
  logic [23:0]     px_sel;

  // Optional brightness shaping; both forms fit in the single output stage.
  function automatic logic [7:0] shape(input logic [7:0] c);
`ifdef WS2812_GAMMA_EN
    logic [15:0] sq;
    sq = c * c;
    return sq[15:8];
`else
    return c;
`endif
  endfunction

  // The back buffer is frozen while a swap is pending so the committed frame
  // cannot be altered between commit and the copy at LATCH.
  assign wr_ready = ~swap_pending;

  // Frame boundary: first frame after a commit from IDLE, or the end of the
  // frame period in WAIT (re-sending the front buffer if nothing new arrived).
  assign latch_go = ((state == S_IDLE) && swap_pending) ||
                    ((state == S_WAIT) && (timer == TIMER_MAX));

  // ---- host write stage: back buffer ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) back[i] <= '0;
    end else if (wr_valid && wr_ready && ({1'b0, wr_addr} < LED_LIMIT)) begin
      // Out-of-range indices are accepted by the handshake but dropped here.
      back[wr_addr] <= wr_data;
    end
  end

  // ---- frame control: FSM, timer, swap into the front buffer ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      timer         <= '0;
      rst_cnt       <= '0;
      served        <= '0;
      swap_pending  <= 1'b0;
      commit_done   <= 1'b0;
      drv_reset     <= 1'b1;
      busy          <= 1'b0;
      frame_overrun <= 1'b0;
      for (int i = 0; i < DEPTH; i++) front[i] <= '0;
    end else begin
      commit_done <= 1'b0;

      // A second commit before the swap is simply absorbed.
      if (commit && !swap_pending) swap_pending <= 1'b1;

      // Timer runs from LATCH entry and parks at the last cycle of the period.
      if ((state != S_IDLE) && (timer != TIMER_MAX)) timer <= timer + 1'b1;

      case (state)
        S_LATCH: begin
          if (rst_cnt == RST_LAST) begin
            state     <= S_STREAM;
            drv_reset <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        S_STREAM: begin
          // Streaming is never cut short; the overrun is only recorded and
          // WAIT then falls straight through to the next LATCH.
          if (timer == TIMER_MAX) frame_overrun <= 1'b1;
          if (drv_new_address) begin
            served <= served + 1'b1;
            if (served == SERVED_LAST) state <= S_WAIT;
          end
        end
        default: ;
      endcase

      // LATCH entry overrides the timer/counter updates above.
      if (latch_go) begin
        state     <= S_LATCH;
        timer     <= '0;
        rst_cnt   <= '0;
        served    <= '0;
        drv_reset <= 1'b1;
        busy      <= 1'b1;
        if (swap_pending) begin
          for (int i = 0; i < DEPTH; i++) front[i] <= back[i];
          swap_pending <= 1'b0;
          commit_done  <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    px_sel = '0;
    if ({1'b0, drv_address} < LED_LIMIT) px_sel = front[drv_address];
  end

  // ---- pixel output stage: one cycle after drv_address ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      red_out   <= '0;
      green_out <= '0;
      blue_out  <= '0;
    end else begin
      red_out   <= shape(px_sel[23:16]);
      green_out <= shape(px_sel[15:8]);
      blue_out  <= shape(px_sel[7:0]);
    end
  end

endmodule

// File: doc/ws2812_frame_sched.md
Name: ws2812_frame_sched

Overview:
- Frame scheduler and double-buffered pixel store that feeds a ws2812c-style serial LED driver.
- A host writes pixels into a back buffer and commits the frame. At the next frame boundary the back buffer becomes the front buffer.
- The block pulses the driver's reset to start each frame, serves the driver's address requests from the front buffer, and paces frames at a fixed rate.
- Sits between pattern generators (triwave/dimmer logic) and the LED driver in a top-level design.

Parameters:
- NUM_LEDS, 8, number of pixels per frame (1..256).
- ADDR_BITS, 3, width of pixel addresses; must satisfy 2^ADDR_BITS >= NUM_LEDS.
- FRAME_CYCLES, 800_000, clk cycles per frame period (60 Hz at 48 MHz); must be > RESET_CYCLES + 2.
- RESET_CYCLES, 16, cycles the driver reset is held high at frame start.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- wr_valid  in  1  host pixel write request.
- wr_ready  out  1  back buffer accepts the write.
- wr_addr  in  ADDR_BITS  pixel index to write.
- wr_data  in  24  pixel, {red[23:16], green[15:8], blue[7:0]}.
- commit  in  1  one-cycle pulse: back buffer complete.
- commit_done  out  1  one-cycle pulse when the buffer swap occurs.
- drv_reset  out  1  active-high reset to the driver.
- drv_address  in  ADDR_BITS  pixel index requested by the driver.
- drv_new_address  in  1  driver strobe: it has moved to drv_address.
- red_out, green_out, blue_out  out  8 each  pixel data for the driver.
- busy  out  1  high outside IDLE.
- frame_overrun  out  1  sticky flag: streaming outlasted the frame period.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State goes to IDLE; frame timer and served counter are cleared.
  - drv_reset=1, wr_ready=1, commit_done=0, busy=0, frame_overrun=0.
  - Colour outputs = 0; both buffers are cleared to 0.
- Writes:
  - A write occurs when wr_valid && wr_ready; wr_data is stored to back[wr_addr].
  - wr_addr >= NUM_LEDS: the write is accepted and discarded.
  - wr_ready=0 while swap_pending.
- Commit:
  - commit sets swap_pending. A commit while swap_pending is already set is ignored.
  - If commit coincides with an accepted write, the write lands before the swap.
- State machine:
  - IDLE: drv_reset=1. Leaves to LATCH on swap_pending; this swap also happens at the LATCH entry defined below.
  - LATCH:
    - On entry, the frame timer resets to 0.
    - If swap_pending: front<=back (whole-array copy in one cycle), swap_pending clears, commit_done pulses for 1 cycle.
    - drv_reset=1 for RESET_CYCLES cycles, then go to STREAM.
  - STREAM:
    - drv_reset=0. Each drv_new_address increments the served counter.
    - When served reaches NUM_LEDS, go to WAIT.
  - WAIT: when the frame timer reaches FRAME_CYCLES-1, go to LATCH. Frames repeat continuously after the first commit, re-sending the front buffer when no new commit has arrived.
- Frame timer:
  - Free-runs from LATCH entry and saturates at FRAME_CYCLES-1.
  - If it saturates while still in STREAM, frame_overrun is set (sticky until reset). STREAM is not cut short; WAIT then exits on its next cycle.
- Pixel path:
  - red_out/green_out/blue_out are registered from front[drv_address]; latency is 1 cycle.
  - drv_address >= NUM_LEDS outputs 0.
  - Outputs update every cycle, not only on the strobe.
- A commit arriving during STREAM/WAIT waits for the next LATCH; the front buffer is never modified mid-frame.
- Reset mid-frame: immediate return to IDLE, buffers cleared, drv_reset=1.

Optional Feature:
- Macro: WS2812_GAMMA_EN.
- Defined: each colour channel c is output as (c*c)>>8, computed in the same register stage (still 1-cycle latency). Example: 255->254, 128->64, 1->0.
- Undefined: raw buffer values are passed through.

Test Plan:
- Reset, write 8 pixels (pixel i = 24'h010203*i), commit -> commit_done pulse exactly once; drv_reset high 16 cycles then low; address 3 yields red=3, green=6, blue=9 one cycle later.
- Eight drv_new_address strobes, no commit -> WAIT; next LATCH begins exactly FRAME_CYCLES cycles after the previous one, front buffer unchanged.
- Commit during STREAM, then writes -> wr_ready=0 until the swap; pixels of the current frame are unchanged; the new data appears only after the next LATCH.
- Hold strobes back past FRAME_CYCLES (FRAME_CYCLES=100 in test) -> frame_overrun=1 and stays 1; LATCH follows on the cycle after the 8th strobe.
- Assert reset_n=0 mid-STREAM -> busy=0, drv_reset=1 and colour outputs 0 asynchronously; a later frame read returns 0s.
- With WS2812_GAMMA_EN, pixel 24'hFF8001 -> outputs red=254, green=64, blue=0.
